// File: rtl/count_run_controller.sv
// Run/stop/clear sequencer: button edge detect, RUN/STOP/CLEAR FSM, gated
// prescaler producing one-cycle count ticks, and the wrapping count register.
module count_run_controller #(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned COUNT_MAX = 9999,
  parameter int unsigned CW        = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_btn_run,
  input  logic          i_btn_clear,
  output logic [CW-1:0] o_count,
  output logic          o_tick,
  output logic          o_wrap,
  output logic          o_running,
  output logic [1:0]    o_state
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            r_run_prev;
  logic            r_clr_prev;
  logic [DW-1:0]   r_div;
  logic            run_edge;
  logic            clr_edge;
  logic            advance;
  logic            div_last;
  logic            tick;
  logic            clear;
  logic            count_last;

  assign run_edge   = i_btn_run & ~r_run_prev;
  assign clr_edge   = i_btn_clear & ~r_clr_prev;
  // Advance only while staying in RUN, so a stop on the wrap cycle holds TICK_DIV-1
  assign advance    = (state == ST_RUN) && (state_next == ST_RUN);
  assign div_last   = (r_div == DW'(TICK_DIV - 1));
  assign tick       = advance && div_last;
  assign clear      = (state_next == ST_CLEAR);
  assign count_last = (o_count == CW'(COUNT_MAX));
  assign o_state    = 2'(state);

  // Prev levels reset high so a button held through reset release is not an edge
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_run_prev <= 1'b1;
      r_clr_prev <= 1'b1;
    end else begin
      r_run_prev <= i_btn_run;
      r_clr_prev <= i_btn_clear;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_STOP;
    else          state <= state_next;
  end

  // Next state: clear has priority over run/stop; CLEAR ignores edges
  always_comb begin
    state_next = state;
    case (state)
      ST_STOP: begin
        if (clr_edge)      state_next = ST_CLEAR;
        else if (run_edge) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (clr_edge)      state_next = ST_CLEAR;
        else if (run_edge) state_next = ST_STOP;
      end
      ST_CLEAR: state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div <= '0;
    end else if (clear) begin
      r_div <= '0;
    end else if (advance) begin
      r_div <= div_last ? '0 : r_div + DW'(1);
    end
  end

  // Count register and its registered tick/wrap/running flags
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_count   <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
      o_running <= 1'b0;
    end else begin
      o_tick    <= tick;
      o_wrap    <= tick && count_last;
      o_running <= (state_next == ST_RUN);
      if (clear)     o_count <= '0;
      else if (tick) o_count <= count_last ? '0 : o_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_count_run_controller.sv
// Randomised and directed bench for count_run_controller against a cycle-level
// behavioural model (mode, phase count, modular counter).
module tb_count_run_controller;

  localparam int TICK_DIV  = 4;
  localparam int COUNT_MAX = 9;
  localparam int CW        = 4;

  logic          i_clk;
  logic          i_reset;
  logic          i_btn_run;
  logic          i_btn_clear;
  logic [CW-1:0] o_count;
  logic          o_tick;
  logic          o_wrap;
  logic          o_running;
  logic [1:0]    o_state;

  int n_checks;
  int n_fail;

  // Model: mode 0=stop 1=run 2=clear; phase counts cycles spent advancing
  int m_mode;
  int m_phase;
  int m_count;
  int m_tick;
  int m_wrap;
  int m_prev_run;
  int m_prev_clr;

  count_run_controller #(
    .TICK_DIV (TICK_DIV),
    .COUNT_MAX(COUNT_MAX),
    .CW       (CW)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_btn_run  (i_btn_run),
    .i_btn_clear(i_btn_clear),
    .o_count    (o_count),
    .o_tick     (o_tick),
    .o_wrap     (o_wrap),
    .o_running  (o_running),
    .o_state    (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_phase    = 0;
    m_count    = 0;
    m_tick     = 0;
    m_wrap     = 0;
    m_prev_run = 1;
    m_prev_clr = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge i_clk or negedge i_reset);
      if (!i_reset) begin
        model_reset();
      end else begin
        int re;
        int ce;
        re = (i_btn_run && m_prev_run == 0) ? 1 : 0;
        ce = (i_btn_clear && m_prev_clr == 0) ? 1 : 0;
        m_prev_run = int'(i_btn_run);
        m_prev_clr = int'(i_btn_clear);
        m_tick = 0;
        m_wrap = 0;
        if (m_mode == 2) begin
          m_mode = 0;
        end else if (ce == 1) begin
          m_mode  = 2;
          m_count = 0;
          m_phase = 0;
        end else if (re == 1) begin
          m_mode = (m_mode == 1) ? 0 : 1;
        end else if (m_mode == 1) begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            m_tick  = 1;
            m_wrap  = (m_count == COUNT_MAX) ? 1 : 0;
            m_count = (m_count + 1) % (COUNT_MAX + 1);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, just after the active edge
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      chk("cyc_count",   int'(o_count),   m_count);
      chk("cyc_tick",    int'(o_tick),    m_tick);
      chk("cyc_wrap",    int'(o_wrap),    m_wrap);
      chk("cyc_running", int'(o_running), (m_mode == 1) ? 1 : 0);
      chk("cyc_state",   int'(o_state),   m_mode);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int found;
    n_checks    = 0;
    n_fail      = 0;
    i_reset     = 1'b0;
    i_btn_run   = 1'b0;
    i_btn_clear = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_reset = 1'b1;
    edges(50);
    chk("idle_state", int'(o_state), 0);
    chk("idle_count", int'(o_count), 0);

    // Run press at edge k; first tick after k+4
    @(negedge i_clk) i_btn_run = 1'b1;
    edges(1);
    chk("run_state", int'(o_state), 1);
    chk("run_running", int'(o_running), 1);
    @(negedge i_clk) i_btn_run = 1'b0;
    edges(3);
    chk("run_no_tick_yet", int'(o_tick), 0);
    edges(1);
    chk("run_first_tick", int'(o_tick), 1);
    chk("run_first_count", int'(o_count), 1);
    edges(32);
    chk("run_count9", int'(o_count), 9);
    edges(4);
    chk("wrap_count", int'(o_count), 0);
    chk("wrap_tick", int'(o_tick), 1);
    chk("wrap_flag", int'(o_wrap), 1);

    // Stop with phase 2, resume: tick two cycles after re-entry
    edges(2);
    @(negedge i_clk) i_btn_run = 1'b1;
    edges(1);
    chk("pause_state", int'(o_state), 0);
    @(negedge i_clk) i_btn_run = 1'b0;
    edges(20);
    chk("pause_frozen", int'(o_count), 0);
    @(negedge i_clk) i_btn_run = 1'b1;
    edges(1);
    chk("resume_state", int'(o_state), 1);
    @(negedge i_clk) i_btn_run = 1'b0;
    edges(1);
    chk("resume_no_tick", int'(o_tick), 0);
    edges(1);
    chk("resume_tick", int'(o_tick), 1);
    chk("resume_count", int'(o_count), 1);

    // Simultaneous run+clear in RUN: clear wins, held buttons give no more edges
    edges(5);
    @(negedge i_clk) begin
      i_btn_run   = 1'b1;
      i_btn_clear = 1'b1;
    end
    edges(1);
    chk("clr_state", int'(o_state), 2);
    chk("clr_count", int'(o_count), 0);
    chk("clr_tick", int'(o_tick), 0);
    edges(1);
    chk("clr_to_stop", int'(o_state), 0);
    edges(10);
    chk("clr_held_state", int'(o_state), 0);
    @(negedge i_clk) begin
      i_btn_run   = 1'b0;
      i_btn_clear = 1'b0;
    end

    // Stop on the exact wrap cycle suppresses the tick and keeps phase at last
    @(negedge i_clk) i_btn_run = 1'b1;
    edges(1);
    @(negedge i_clk) i_btn_run = 1'b0;
    edges(3);
    @(negedge i_clk) i_btn_run = 1'b1;
    edges(1);
    chk("edge_stop_tick", int'(o_tick), 0);
    chk("edge_stop_state", int'(o_state), 0);
    chk("edge_stop_count", int'(o_count), 0);
    @(negedge i_clk) i_btn_run = 1'b0;
    @(negedge i_clk) i_btn_run = 1'b1;
    edges(1);
    @(negedge i_clk) i_btn_run = 1'b0;
    edges(1);
    chk("edge_resume_tick", int'(o_tick), 1);
    chk("edge_resume_count", int'(o_count), 1);

    // Async reset mid-run at count 7, button held through release
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      edges(1);
      if (o_count == CW'(7)) found = 1;
    end
    chk("reach_count7", found, 1);
    #2;
    i_reset   = 1'b0;
    i_btn_run = 1'b1;
    #1;
    chk("async_count", int'(o_count), 0);
    chk("async_state", int'(o_state), 0);
    chk("async_running", int'(o_running), 0);
    @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    edges(10);
    chk("held_release_state", int'(o_state), 0);
    @(negedge i_clk) i_btn_run = 1'b0;

    // Random button activity with rare resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      if (!i_reset) begin
        if ($urandom_range(0, 2) == 0) i_reset = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        i_reset = 1'b0;
      end
      if ($urandom_range(0, 9) == 0)  i_btn_run   = ~i_btn_run;
      if ($urandom_range(0, 39) == 0) i_btn_clear = ~i_btn_clear;
    end
    @(negedge i_clk) i_reset = 1'b1;
    edges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
